// File: rtl/rgb565_gray_pkg.sv
// Shared constants and types for the RGB565 -> 8-bit grayscale custom instruction.
package rgb565_gray_pkg;

  localparam logic [15:0] GRAY_COEF_R = 16'd54;
  localparam logic [15:0] GRAY_COEF_G = 16'd183;
  localparam logic [15:0] GRAY_COEF_B = 16'd19;

  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  localparam int unsigned PIXELS_PER_OP = 4;
  localparam logic [1:0]  LAST_IDX      = 2'(PIXELS_PER_OP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rgb565_to_gray8.sv
// Combinational RGB565 pixel to 8-bit gray: (54*R + 183*G + 19*B) >> 8, truncated.
module rgb565_to_gray8
  import rgb565_gray_pkg::*;
(
  input  logic [15:0] pixel_i,
  output logic [7:0]  gray_o
);

  logic [15:0] r16;
  logic [15:0] g16;
  logic [15:0] b16;
  logic [15:0] sum;

  always_comb begin
    r16    = {11'd0, pixel_i[R_MSB:R_LSB]};
    g16    = {10'd0, pixel_i[G_MSB:G_LSB]};
    b16    = {11'd0, pixel_i[B_MSB:B_LSB]};
    // Max sum is 13792, so 16 bits never overflow.
    sum    = r16 * GRAY_COEF_R + g16 * GRAY_COEF_G + b16 * GRAY_COEF_B;
    gray_o = sum[15:8];
  end

endmodule

// File: rtl/rgb565_gray_pack_ise.sv
// Custom-instruction controller: four RGB565 pixels through one shared gray datapath,
// one pixel per clock, packed into a 32-bit result that is zero outside the done pulse.
module rgb565_gray_pack_ise
  import rgb565_gray_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [63:0] op_q, op_d;
  logic [31:0] pack_q, pack_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic [15:0] pix;
  logic [7:0]  gray;

  assign pix = op_q[{idx_q, 4'b0000} +: 16];

  rgb565_to_gray8 u_gray (
    .pixel_i (pix),
    .gray_o  (gray)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    op_d     = op_q;
    pack_d   = pack_q;
    done_d   = 1'b0;
    result_d = '0;
    case (state_q)
      IDLE: begin
        if (start && (iseId == customInstructionId)) begin
          op_d    = {valueB, valueA};
          idx_d   = '0;
          pack_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        pack_d[{idx_q, 3'b000} +: 8] = gray;
        idx_d = idx_q + 2'd1;
        // Register done/result on the last write so the DONE cycle presents them directly.
        if (idx_q == LAST_IDX) begin
          done_d   = 1'b1;
          result_d = pack_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      pack_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      pack_q   <= pack_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rgb565_gray_pack_ise.sv
// Directed and randomised checks for rgb565_gray_pack_ise against an independent gray model.
module tb_rgb565_gray_pack_ise;

  localparam logic [7:0] ID = 8'h3C;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  rgb565_gray_pack_ise #(.customInstructionId(ID)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .iseId  (iseId),
    .valueA (valueA),
    .valueB (valueB),
    .done   (done),
    .result (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] ref_gray(input logic [15:0] p);
    int unsigned s;
    s = 54 * int'(p[15:11]) + 183 * int'(p[10:5]) + 19 * int'(p[4:0]);
    return s[15:8];
  endfunction

  function automatic logic [31:0] ref_pack(input logic [31:0] a, input logic [31:0] b);
    return {ref_gray(b[31:16]), ref_gray(b[15:0]), ref_gray(a[31:16]), ref_gray(a[15:0])};
  endfunction

  // Issue one op and check done/result for the six cycles that follow (done only after edge 4).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit check_range);
    start  = 1'b1;
    iseId  = ID;
    valueA = a;
    valueB = b;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) begin
        start  = 1'b0;
        valueA = ~a;
        valueB = ~b;
      end
      check({tag, "_done"}, {31'd0, done}, {31'd0, (c == 4)});
      check({tag, "_result"}, result, (c == 4) ? exp : 32'd0);
      if (check_range && c == 4) begin
        for (int k = 0; k < 4; k++) begin
          logic [7:0] byt;
          byt = result[8*k +: 8];
          check({tag, "_range"}, {31'd0, (byt <= 8'd53)}, 32'd1);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    reset  = 1'b0;
    start  = 1'b0;
    iseId  = 8'h00;
    valueA = '0;
    valueB = '0;
    #2;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Test 1: full-scale primaries. 0xFFFF->0x35, 0xF800->0x06, 0x07E0->0x2D, 0x001F->0x02.
    run_op("t1", 32'hF800_FFFF, 32'h001F_07E0, 32'h022D_0635, 1'b0);

    // Test 2: all-black.
    run_op("t2", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

    // Small-value vector: 0x0841 -> (54+366+19)>>8 = 1; 0x1082 -> 878>>8 = 3.
    run_op("t2b", 32'h1082_0841, 32'h0841_1082, 32'h0103_0301, 1'b0);

    // Test 3: non-matching id is ignored.
    start  = 1'b1;
    iseId  = 8'h5A;
    valueA = 32'hFFFF_FFFF;
    valueB = 32'hFFFF_FFFF;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) start = 1'b0;
      check("t3_done", {31'd0, done}, 32'd0);
      check("t3_result", result, 32'd0);
    end

    // Test 4: extra starts during CONV and DONE are ignored.
    start  = 1'b1;
    iseId  = ID;
    valueA = 32'hF800_FFFF;
    valueB = 32'h001F_07E0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        valueA = 32'h1234_5678;
        valueB = 32'h9ABC_DEF0;
      end
      if (c == 4) start = 1'b0;
      check("t4_done", {31'd0, done}, {31'd0, (c == 4)});
      check("t4_result", result, (c == 4) ? 32'h022D_0635 : 32'd0);
    end
    run_op("t4_next", 32'h1234_5678, 32'h9ABC_DEF0,
           ref_pack(32'h1234_5678, 32'h9ABC_DEF0), 1'b0);

    // Test 5: reset mid-operation aborts.
    start  = 1'b1;
    iseId  = ID;
    valueA = 32'hFFFF_FFFF;
    valueB = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #2;
    check("t5_rst_done", {31'd0, done}, 32'd0);
    check("t5_rst_result", result, 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("t5_done", {31'd0, done}, 32'd0);
      check("t5_result", result, 32'd0);
    end
    run_op("t5_fresh", 32'hF800_FFFF, 32'h001F_07E0, 32'h022D_0635, 1'b0);

    // Test 6: random ops with random gaps.
    for (int n = 0; n < 1000; n++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        tick();
        check("t6_gap_done", {31'd0, done}, 32'd0);
      end
      a = $urandom;
      b = $urandom;
      run_op("t6", a, b, ref_pack(a, b), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
